// File: rtl/div255_pkg.sv
// div255_pkg: shared widths, tag/result types and default sizing for the div255 arbiter slice.
package div255_pkg;
   localparam int DATA_W         = 32;
   localparam int DIV_LAT_DEF    = 4;
   localparam int FIFO_DEPTH_DEF = 4;
   typedef logic tag_t;
   typedef struct packed {
      tag_t                     tag;
      logic signed [DATA_W-1:0] y;
   } res_t;
endpackage

// File: rtl/div255_arbiter_if.sv
// div255_arbiter_if: two-requester issue bundle plus the result handshake of div255_arbiter.
interface div255_arbiter_if;
   import div255_pkg::*;
   logic [1:0]               in_valid;
   logic signed [DATA_W-1:0] in_x0;
   logic signed [DATA_W-1:0] in_x1;
   logic [1:0]               in_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_y;
   tag_t                     out_tag;
   modport master (
      output in_valid, in_x0, in_x1, out_ready,
      input  in_ready, out_valid, out_y, out_tag
   );
   modport slave (
      input  in_valid, in_x0, in_x1, out_ready,
      output in_ready, out_valid, out_y, out_tag
   );
endinterface

// File: rtl/div255_arbiter_div255.sv
// div255: signed x/255 truncated toward zero, LAT register stages from x to y.
module div255 #(
   parameter int LAT = 4
) (
   input  logic signed [31:0] x,
   input  logic               clk,
   output logic signed [31:0] y
);
   logic               neg;
   logic [31:0]        mag;
   logic [31:0]        quo;
   logic signed [31:0] pipe_q [LAT];
   // 0x80808081 >> 39 is an exact reciprocal of 255 for every 32-bit unsigned magnitude
   always_comb begin
      neg = x[31];
      mag = neg ? -x : x;
      quo = 32'(({32'd0, mag} * 64'h0000_0000_8080_8081) >> 39);
   end
   always_ff @(posedge clk) begin
      pipe_q[0] <= neg ? -$signed(quo) : $signed(quo);
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i - 1];
   end
   assign y = pipe_q[LAT - 1];
endmodule

// File: rtl/div255_arbiter.sv
// div255_arbiter: round-robin two-requester front end for div255 with a credit-guarded result FIFO.
// Defining DIV255_ARB_STATS_EN adds 16-bit per-requester grant counters grant_cnt0/grant_cnt1.
module div255_arbiter
   import div255_pkg::*;
#(
   parameter int DIV_LAT    = DIV_LAT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input logic             clk,
   input logic             rst_n,
   div255_arbiter_if.slave bus
`ifdef DIV255_ARB_STATS_EN
   ,
   output logic [15:0]     grant_cnt0,
   output logic [15:0]     grant_cnt1
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   logic [CW-1:0]            count_q, count_d;
   logic                     last_q, last_d;
   logic [DIV_LAT-1:0]       vld_q, vld_d;
   logic [DIV_LAT-1:0]       tag_q, tag_d;
   logic [PW-1:0]            wr_q, wr_d, rd_q, rd_d;
   res_t                     mem_q [FIFO_DEPTH];
   logic                     open, win, accept, pop, push, empty;
   logic signed [DATA_W-1:0] div_x, div_y;

   // credits cover in-flight results too, so every push finds a free slot
   always_comb begin
      empty   = (wr_q == rd_q);
      open    = rst_n && (count_q != CW'(FIFO_DEPTH));
      win     = (bus.in_valid == 2'b11) ? ~last_q : bus.in_valid[1];
      accept  = open && bus.in_valid[win];
      pop     = !empty && bus.out_ready;
      push    = vld_q[DIV_LAT-1];
      count_d = count_q + CW'(accept) - CW'(pop);
      last_d  = accept ? win : last_q;
      vld_d   = DIV_LAT'({vld_q, accept});
      tag_d   = DIV_LAT'({tag_q, win});
      wr_d    = wr_q + PW'(push);
      rd_d    = rd_q + PW'(pop);
      div_x   = accept ? (win ? bus.in_x1 : bus.in_x0) : '0;
   end

   assign bus.in_ready  = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign bus.out_valid = !empty;
   assign bus.out_y     = empty ? '0 : mem_q[rd_q[AW-1:0]].y;
   assign bus.out_tag   = empty ? 1'b0 : mem_q[rd_q[AW-1:0]].tag;

   div255 #(.LAT(DIV_LAT)) u_div (
      .x   (div_x),
      .clk (clk),
      .y   (div_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         last_q  <= 1'b1;
         vld_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         count_q <= count_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      if (push) mem_q[wr_q[AW-1:0]] <= '{tag: tag_q[DIV_LAT-1], y: div_y};
   end

`ifdef DIV255_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_q + 16'(accept && !win);
         cnt1_q <= cnt1_q + 16'(accept && win);
      end
   end
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_div255_arbiter.sv
// tb_div255_arbiter: directed cycle-by-cycle checks of arbitration, credits, latency, ordering and reset.
module tb_div255_arbiter;
   import div255_pkg::*;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;

   div255_arbiter_if bus ();
`ifdef DIV255_ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1;
`endif

   div255_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DIV255_ARB_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // start a new cycle: apply inputs just after the edge, then let them settle
   task automatic step(input logic r, input logic o, input logic [1:0] v, input int x0, input int x1);
      @(posedge clk);
      #1;
      rst_n         = r;
      bus.out_ready = o;
      bus.in_valid  = v;
      bus.in_x0     = x0;
      bus.in_x1     = x1;
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input int y, input logic t);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, "_y"}, bus.out_y, y);
      chk({tag, "_tag"}, 32'(bus.out_tag), 32'(t));
   endtask

   int xv [4] = '{255, 254, -510, -254};
   int yv [4] = '{1, 0, -2, 0};

   initial begin
      // reset: in_ready forced low, outputs zero after the reset edge
      step(0, 1, 2'b11, 7, 7);
      chk("rst_ready", 32'(bus.in_ready), 0);
      step(0, 1, 2'b00, 0, 0);
      step(1, 1, 2'b00, 0, 0);
      chk_out("rst_out", 0, 0, 0);
      chk("idle_ready", 32'(bus.in_ready), 0);

      // single req0 request: result appears DIV_LAT+1 cycles later
      step(1, 1, 2'b01, 255000, 0);
      chk("single_ready", 32'(bus.in_ready), 1);
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 2'b00, 0, 0);
         chk("single_lat", 32'(bus.out_valid), 0);
      end
      step(1, 1, 2'b00, 0, 0);
      chk_out("single_out", 1, 1000, 0);
      step(1, 1, 2'b00, 0, 0);
      chk("single_drain", 32'(bus.out_valid), 0);

      // truncation toward zero, issued back to back from req1
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 2'b10, 0, xv[k]);
         chk("trunc_ready", 32'(bus.in_ready), 2);
      end
      step(1, 1, 2'b00, 0, 0);
      chk("trunc_lat", 32'(bus.out_valid), 0);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 2'b00, 0, 0);
         chk_out("trunc_out", 1, yv[k], 1);
      end
      step(1, 1, 2'b00, 0, 0);
      chk("trunc_drain", 32'(bus.out_valid), 0);

      // both valid: alternate starting with req0 (req1 won last), credits run out after 4
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 2'b11, 2550, 1020);
         chk("rr_ready", 32'(bus.in_ready), (k % 2) ? 2 : 1);
      end
      step(1, 1, 2'b11, 2550, 1020);
      chk("rr_full", 32'(bus.in_ready), 0);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 2'b00, 0, 0);
         chk_out("rr_out", 1, (k % 2) ? 4 : 10, 1'(k % 2));
      end
      step(1, 1, 2'b00, 0, 0);
      chk("rr_drain", 32'(bus.out_valid), 0);

      // backpressure: 6 requests from req1 with out_ready low
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 2'b10, 0, 255 * (10 + k));
         chk("bp_ready", 32'(bus.in_ready), 2);
      end
      step(1, 0, 2'b10, 0, 255 * 14);
      chk("bp_full", 32'(bus.in_ready), 0);
      step(1, 0, 2'b10, 0, 255 * 14);
      chk_out("bp_head", 1, 10, 1);
      step(1, 0, 2'b10, 0, 255 * 14);
      step(1, 0, 2'b10, 0, 255 * 14);
      step(1, 0, 2'b10, 0, 255 * 14);
      chk("bp_full2", 32'(bus.in_ready), 0);
      chk_out("bp_hold", 1, 10, 1);
      step(1, 1, 2'b10, 0, 255 * 14);
      chk("bp_pop0_ready", 32'(bus.in_ready), 0);
      chk_out("bp_pop0", 1, 10, 1);
      step(1, 1, 2'b10, 0, 255 * 14);
      chk("bp_pop1_ready", 32'(bus.in_ready), 2);
      chk_out("bp_pop1", 1, 11, 1);
      step(1, 1, 2'b10, 0, 255 * 15);
      chk("bp_pop2_ready", 32'(bus.in_ready), 2);
      chk_out("bp_pop2", 1, 12, 1);
      step(1, 1, 2'b00, 0, 0);
      chk_out("bp_pop3", 1, 13, 1);
      step(1, 1, 2'b00, 0, 0);
      chk_out("bp_empty", 0, 0, 0);
      step(1, 1, 2'b00, 0, 0);
      step(1, 1, 2'b00, 0, 0);
      chk_out("bp_late0", 1, 14, 1);
      step(1, 1, 2'b00, 0, 0);
      chk_out("bp_late1", 1, 15, 1);
      step(1, 1, 2'b00, 0, 0);
      chk("bp_drain", 32'(bus.out_valid), 0);

      // reset with three results in flight: they must vanish, req0 wins first afterwards
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 2'b01, 2550, 0);
         chk("flush_ready", 32'(bus.in_ready), 1);
      end
      step(0, 1, 2'b11, 2550, 1020);
      chk("flush_rst_ready", 32'(bus.in_ready), 0);
      step(1, 1, 2'b11, 25500, 1020);
      chk("flush_first_grant", 32'(bus.in_ready), 1);
      chk("flush_quiet", 32'(bus.out_valid), 0);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 2'b00, 0, 0);
         chk("flush_quiet", 32'(bus.out_valid), 0);
      end
      step(1, 1, 2'b00, 0, 0);
      chk_out("flush_new", 1, 100, 0);
      step(1, 1, 2'b00, 0, 0);
      chk("flush_drain", 32'(bus.out_valid), 0);

`ifdef DIV255_ARB_STATS_EN
      step(0, 1, 2'b00, 0, 0);
      step(1, 1, 2'b00, 0, 0);
      chk("stat_rst0", 32'(grant_cnt0), 0);
      chk("stat_rst1", 32'(grant_cnt1), 0);
      for (int k = 0; k < 8; k++) begin
         step(1, 1, (k < 5) ? 2'b01 : 2'b10, 255, 255);
         chk("stat_ready", 32'(bus.in_ready), (k < 5) ? 1 : 2);
         for (int j = 0; j < 5; j++) step(1, 1, 2'b00, 0, 0);
      end
      chk("stat_cnt0", 32'(grant_cnt0), 5);
      chk("stat_cnt1", 32'(grant_cnt1), 3);
      step(0, 1, 2'b00, 0, 0);
      step(1, 1, 2'b00, 0, 0);
      chk("stat_clr0", 32'(grant_cnt0), 0);
      chk("stat_clr1", 32'(grant_cnt1), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/div255_arbiter.md
DIV255_ARBITER -- requirements
Module: div255_arbiter

Interface
REQ-001 SHALL have parameter DIV_LAT, default 4: cycles from div255 input x to matching y; must equal the instantiated div255 latency.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 2: bit i is requester i's request.
REQ-006 SHALL have port in_x0, input, 32: signed dividend from requester 0.
REQ-007 SHALL have port in_x1, input, 32: signed dividend from requester 1.
REQ-008 SHALL have port in_ready, output, 2: bit i means requester i is accepted this cycle.
REQ-009 SHALL have port out_valid, output, 1: FIFO head is valid.
REQ-010 SHALL have port out_ready, input, 1: consumer pops the head when out_valid is also high.
REQ-011 SHALL have port out_y, output, 32: signed quotient x/255 at FIFO head.
REQ-012 SHALL have port out_tag, output, 1: requester index of the head result.

Function
REQ-013 SHALL accept at most one request per cycle; acceptance is in_valid[i] && in_ready[i]; at most one in_ready bit is high.
REQ-014 SHALL arbitrate round-robin: sole requester wins; when both are valid, the one not granted last wins; the last-grant pointer updates only on acceptance.
REQ-015 SHALL keep a registered credit count (in flight plus FIFO occupancy), range 0..FIFO_DEPTH; in_ready is all-zero when count == FIFO_DEPTH.
REQ-016 SHALL compute in_ready from the registered count, so a pop frees a credit from the next cycle; simultaneous issue and pop leave count unchanged.
REQ-017 SHALL drive the accepted in_x combinationally to div255 x in the accept cycle c; otherwise div255 x is 0.
REQ-018 SHALL run a DIV_LAT-deep valid+tag shift register alongside div255, and push {tag, y} into the FIFO at the end of cycle c+DIV_LAT.
REQ-019 SHALL first assert the result on out_valid in cycle c+DIV_LAT+1; results leave in issue order, with no bypass.
REQ-020 SHALL never overflow the FIFO; the credit scheme guarantees a free slot at every push.
REQ-021 SHALL hold out_y and out_tag stable while out_valid && !out_ready, and drive both to 0 when the FIFO is empty.
REQ-022 SHALL produce the quotient truncated toward zero, as div255 computes it; the arbiter does no arithmetic on data.

Reset
REQ-023 SHALL, when rst_n is low at a clock edge, clear count, pipeline valids, FIFO pointers and statistics, and set the pointer so requester 0 wins first.
REQ-024 SHALL force in_ready = 2'b00 while rst_n is low; out_valid, out_y and out_tag read 0 from the edge after reset.
REQ-025 SHALL discard in-flight and buffered results on reset mid-operation; none appear afterwards.

Configuration
REQ-026 SHALL, with DIV255_ARB_STATS_EN defined, add outputs grant_cnt0 and grant_cnt1 (16 bits each); each counts acceptances per requester, wraps 65535 to 0, and is cleared by reset.
REQ-027 SHALL, without DIV255_ARB_STATS_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-028 SHALL place data width 32, the tag type and the default DIV_LAT / FIFO_DEPTH constants in the shared package div255_pkg.
REQ-029 SHALL instantiate the existing div255 (x, clk, y) unchanged as its single datapath sub-module; the FIFO is inline RTL.

Verification
REQ-030 SHALL cover: req0 x=255000 alone, out_ready=1 -> out_valid in cycle c+DIV_LAT+1, out_y=1000, out_tag=0.
REQ-031 SHALL cover: both valid continuously, x0=2550 and x1=1020 -> grants 0,1,0,1...; outputs alternate 10/tag0 and 4/tag1.
REQ-032 SHALL cover: out_ready=0, 6 requests from req1, FIFO_DEPTH=4 -> exactly 4 accepted, then in_ready=00; raise out_ready -> 4 results in order, then the remaining 2 accepted.
REQ-033 SHALL cover: inputs 255, 254, -510, -254 -> outputs 1, 0, -2, 0, in order.
REQ-034 SHALL cover: rst_n low one cycle with 3 results in flight -> out_valid never rises for them; with both requesters valid afterwards, first grant is to req0.
REQ-035 SHALL cover, with DIV255_ARB_STATS_EN: 5 accepts req0 and 3 accepts req1 -> grant_cnt0=5, grant_cnt1=3; after reset both are 0.
